// File: rtl/shift_ext_unit_pkg.sv
// Shared encodings for the iterative shifter / immediate extender.
// Flag outputs are built only with JALA_SHIFT_FLAGS_EN.
package shift_ext_pkg;
    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_ext_unit_if.sv
// Request/result bundle between the control FSM and the shift/extend unit.
// ShiftZero/ShiftCarry exist only with JALA_SHIFT_FLAGS_EN.
interface shift_ext_unit_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5,
    parameter int IMM_W = 12
);
    logic             Start;
    logic             Ready;
    logic             Done;
    logic             Flush;
    logic [1:0]       Mode;
    logic             Dir;
    logic [AMT_W-1:0] Amt;
    logic [WIDTH-1:0] ShiftIn;
    logic [WIDTH-1:0] ShiftOut;
    logic [IMM_W-1:0] Imm;
    logic             ImmSigned;
    logic [WIDTH-1:0] ExtOut;
`ifdef JALA_SHIFT_FLAGS_EN
    logic             ShiftZero;
    logic             ShiftCarry;

    modport master (output Start, Flush, Mode, Dir, Amt, ShiftIn, Imm, ImmSigned,
                    input  Ready, Done, ShiftOut, ExtOut, ShiftZero, ShiftCarry);
    modport slave  (input  Start, Flush, Mode, Dir, Amt, ShiftIn, Imm, ImmSigned,
                    output Ready, Done, ShiftOut, ExtOut, ShiftZero, ShiftCarry);
`else
    modport master (output Start, Flush, Mode, Dir, Amt, ShiftIn, Imm, ImmSigned,
                    input  Ready, Done, ShiftOut, ExtOut);
    modport slave  (input  Start, Flush, Mode, Dir, Amt, ShiftIn, Imm, ImmSigned,
                    output Ready, Done, ShiftOut, ExtOut);
`endif
endinterface

// File: rtl/shift_ext_unit_shift_step.sv
// One iteration of the shifter: moves i_val by i_cnt (0..STEP) bits and
// reports the last bit that left the word (or wrapped, for rotate).
module shift_step
    import shift_ext_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = 5
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_val,
    output logic             o_carry
);
    logic             w_rot;
    logic             w_ari;
    logic [WIDTH-1:0] w_tmp;

    assign w_rot = (i_mode == MODE_ROT);
    assign w_ari = (i_mode == MODE_ARI);

    // Shift amounts are constants per branch so each count is a fixed wiring pattern.
    always_comb begin
        o_val   = i_val;
        o_carry = 1'b0;
        w_tmp   = '0;
        for (int k = 1; k <= STEP; k++) begin
            if (i_cnt == CNT_W'(k)) begin
                if (i_dir == DIR_LEFT) begin
                    w_tmp   = i_val >> (WIDTH - k);
                    o_carry = w_tmp[0];
                    o_val   = w_rot ? ((i_val << k) | (i_val >> (WIDTH - k))) : (i_val << k);
                end else begin
                    w_tmp   = i_val >> (k - 1);
                    o_carry = w_tmp[0];
                    if (w_rot)
                        o_val = (i_val >> k) | (i_val << (WIDTH - k));
                    else if (w_ari)
                        o_val = (i_val >> k) | ({WIDTH{i_sign}} << (WIDTH - k));
                    else
                        o_val = i_val >> k;
                end
            end
        end
    end
endmodule

// File: rtl/shift_ext_unit.sv
// Multi-cycle shifter (STEP bits/cycle) with registered immediate extender.
// Defining JALA_SHIFT_FLAGS_EN adds registered ShiftZero/ShiftCarry outputs.
module shift_ext_unit
    import shift_ext_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = 5,
    parameter int IMM_W = 12
) (
    input  logic CLK,
    input  logic CtrlRstN,
    shift_ext_unit_if.slave sif
);
    localparam int              RW     = $clog2(WIDTH + 1);
    localparam logic [AMT_W:0]  W_X    = (AMT_W + 1)'(WIDTH);
    localparam logic [RW-1:0]   STEP_X = RW'(STEP);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_work, r_shift_out, r_ext_out;
    logic [WIDTH-1:0] w_step_val, w_ext;
    logic [RW-1:0]    r_rem, w_aeff, w_cnt;
    logic [1:0]       r_mode;
    logic             r_dir, r_sign;
    logic             w_step_carry, w_accept, w_last;
    logic [AMT_W:0]   w_amt_x, w_aeff_x;

    assign w_amt_x = {1'b0, sif.Amt};

    // Rotate wraps the amount; linear shifts saturate at a full-width shift.
    always_comb begin
        if (sif.Mode == MODE_ROT) w_aeff_x = w_amt_x % W_X;
        else                      w_aeff_x = (w_amt_x > W_X) ? W_X : w_amt_x;
    end

    assign w_aeff   = RW'(w_aeff_x);
    assign w_ext    = sif.ImmSigned ? WIDTH'($signed(sif.Imm)) : WIDTH'(sif.Imm);
    assign w_cnt    = (r_rem > STEP_X) ? STEP_X : r_rem;
    assign w_last   = (r_rem == w_cnt);
    assign w_accept = (r_state == ST_IDLE) && sif.Start && !sif.Flush;

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(RW)) u_step (
        .i_val   (r_work),
        .i_cnt   (w_cnt),
        .i_mode  (r_mode),
        .i_dir   (r_dir),
        .i_sign  (r_sign),
        .o_val   (w_step_val),
        .o_carry (w_step_carry)
    );

    always_comb begin
        w_next    = r_state;
        sif.Ready = (r_state == ST_IDLE);
        sif.Done  = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = (w_aeff == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (sif.Flush) w_next = ST_IDLE;
                      else if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CtrlRstN) begin
        if (!CtrlRstN) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

`ifdef JALA_SHIFT_FLAGS_EN
    logic r_zero, r_carry;
    assign sif.ShiftZero  = r_zero;
    assign sif.ShiftCarry = r_carry;
`else
    logic w_carry_unused;
    assign w_carry_unused = w_step_carry;
`endif

    always_ff @(posedge CLK or negedge CtrlRstN) begin
        if (!CtrlRstN) begin
            r_work      <= '0;
            r_shift_out <= '0;
            r_ext_out   <= '0;
            r_rem       <= '0;
            r_mode      <= MODE_LOG;
            r_dir       <= DIR_LEFT;
            r_sign      <= 1'b0;
`ifdef JALA_SHIFT_FLAGS_EN
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work    <= sif.ShiftIn;
            r_mode    <= sif.Mode;
            r_dir     <= sif.Dir;
            r_sign    <= sif.ShiftIn[WIDTH-1];
            r_rem     <= w_aeff;
            r_ext_out <= w_ext;
            if (w_aeff == '0) begin
                r_shift_out <= sif.ShiftIn;
`ifdef JALA_SHIFT_FLAGS_EN
                r_zero      <= (sif.ShiftIn == '0);
                r_carry     <= 1'b0;
`endif
            end
        end else if (r_state == ST_SHIFT && !sif.Flush) begin
            r_work <= w_step_val;
            r_rem  <= r_rem - w_cnt;
            if (w_last) begin
                r_shift_out <= w_step_val;
`ifdef JALA_SHIFT_FLAGS_EN
                r_zero      <= (w_step_val == '0);
                r_carry     <= w_step_carry;
`endif
            end
        end
    end

    assign sif.ShiftOut = r_shift_out;
    assign sif.ExtOut   = r_ext_out;
endmodule

// File: tb/tb_shift_ext_unit.sv
// Bench for shift_ext_unit: arithmetic reference model plus directed literal
// checks and a randomized run; flag checks compile in with JALA_SHIFT_FLAGS_EN.
module tb_shift_ext_unit;
    localparam int WIDTH = 16;
    localparam int STEP  = 1;
    localparam int AMT_W = 5;
    localparam int IMM_W = 12;

    logic CLK      = 1'b0;
    logic CtrlRstN = 1'b0;
    always #5 CLK = ~CLK;

    shift_ext_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W), .IMM_W(IMM_W)) sif();

    shift_ext_unit #(.WIDTH(WIDTH), .STEP(STEP), .AMT_W(AMT_W), .IMM_W(IMM_W)) dut (
        .CLK      (CLK),
        .CtrlRstN (CtrlRstN),
        .sif      (sif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int aeff_of(input int md, input int amt);
        if (md == 2) return amt % WIDTH;
        return (amt > WIDTH) ? WIDTH : amt;
    endfunction

    // Returns {carry, result} straight from the shift definitions.
    function automatic logic [16:0] ref_shift(input int md, input int dr, input int amt, input int x);
        int a, r, c;
        int signed sx;
        a = aeff_of(md, amt);
        if (a == 0) return {1'b0, x[15:0]};
        if (dr == 0) begin
            c = (x >> (WIDTH - a)) & 1;
            r = (md == 2) ? ((x << a) | (x >> (WIDTH - a))) : (x << a);
        end else begin
            c = (x >> (a - 1)) & 1;
            if (md == 2) r = (x >> a) | (x << (WIDTH - a));
            else if (md == 1) begin
                sx = x[15] ? (x - 65536) : x;
                r  = sx >>> a;
            end else r = x >> a;
        end
        return {c[0], r[15:0]};
    endfunction

    function automatic logic [15:0] ref_ext(input int imm, input int isg);
        int v;
        v = imm;
        if (isg != 0 && imm[11]) v = v | 32'h0000_F000;
        return v[15:0];
    endfunction

    // Expected-output state, advanced once per clock edge.
    logic        m_ready = 1'b1, m_done = 1'b0;
    logic [15:0] m_shift = '0, m_ext = '0;
    logic [16:0] m_pend = '0;
    logic        m_zero = 1'b0, m_carry = 1'b0;
    int          m_left = 0;

    initial forever begin
        @(posedge CLK or negedge CtrlRstN);
        if (!CtrlRstN) begin
            m_ready = 1'b1; m_done = 1'b0; m_shift = '0; m_ext = '0;
            m_left = 0; m_zero = 1'b0; m_carry = 1'b0;
        end else if (m_done) begin
            m_done  = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            if (sif.Start && !sif.Flush) begin
                int a;
                a       = aeff_of(int'(sif.Mode), int'(sif.Amt));
                m_pend  = ref_shift(int'(sif.Mode), int'(sif.Dir), int'(sif.Amt), int'(sif.ShiftIn));
                m_ext   = ref_ext(int'(sif.Imm), int'(sif.ImmSigned));
                m_ready = 1'b0;
                if (a == 0) begin
                    m_shift = m_pend[15:0]; m_carry = 1'b0; m_zero = (m_pend[15:0] == 0);
                    m_done  = 1'b1;
                end else m_left = (a + STEP - 1) / STEP;
            end
        end else if (sif.Flush) begin
            m_ready = 1'b1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_shift = m_pend[15:0]; m_carry = m_pend[16]; m_zero = (m_pend[15:0] == 0);
                m_done  = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        chk("ready", sif.Ready, m_ready);
        chk("done", sif.Done, m_done);
        chk("shiftout", sif.ShiftOut, m_shift);
        chk("extout", sif.ExtOut, m_ext);
`ifdef JALA_SHIFT_FLAGS_EN
        chk("zero", sif.ShiftZero, m_zero);
        chk("carry", sif.ShiftCarry, m_carry);
`endif
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Issues one request from idle and returns in the Done cycle.
    task automatic req(input logic [1:0] md, input logic dr, input logic [4:0] am,
                       input logic [15:0] x, input logic [11:0] im, input logic isg,
                       output int cyc);
        sif.Mode = md; sif.Dir = dr; sif.Amt = am; sif.ShiftIn = x;
        sif.Imm = im; sif.ImmSigned = isg; sif.Start = 1'b1;
        tick();
        sif.Start = 1'b0;
        cyc = 1;
        while (!sif.Done && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!sif.Done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        int picks[5] = '{0, 15, 16, 17, 31};
        sif.Start = 0; sif.Flush = 0; sif.Mode = 0; sif.Dir = 0; sif.Amt = 0;
        sif.ShiftIn = 0; sif.Imm = 0; sif.ImmSigned = 0;
        tick(); tick();
        chk("rst_ready", sif.Ready, 1);
        chk("rst_done", sif.Done, 0);
        chk("rst_shiftout", sif.ShiftOut, 0);
        chk("rst_extout", sif.ExtOut, 0);
        CtrlRstN = 1'b1;
        tick();

        req(2'b00, 1'b0, 5'd4, 16'h00F1, 12'h800, 1'b1, cyc);
        chk("t1_cyc", cyc, 5);
        chk("t1_out", sif.ShiftOut, 16'h0F10);
        chk("t1_ext_s", sif.ExtOut, 16'hF800);
        tick();
        req(2'b00, 1'b0, 5'd4, 16'h00F1, 12'h800, 1'b0, cyc);
        chk("t1_ext_z", sif.ExtOut, 16'h0800);
        tick();

        req(2'b01, 1'b1, 5'd15, 16'h8000, 12'h0, 1'b0, cyc);
        chk("t2a_cyc", cyc, 16);
        chk("t2a_out", sif.ShiftOut, 16'hFFFF);
        tick();
        req(2'b01, 1'b1, 5'd20, 16'h8000, 12'h0, 1'b0, cyc);
        chk("t2b_cyc", cyc, 17);
        chk("t2b_out", sif.ShiftOut, 16'hFFFF);
        tick();

        req(2'b10, 1'b1, 5'd20, 16'h1234, 12'h0, 1'b0, cyc);
        chk("t3_cyc", cyc, 1 + (4 + STEP - 1) / STEP);
        chk("t3_out", sif.ShiftOut, 16'h4123);
        tick();

        req(2'b00, 1'b0, 5'd0, 16'hBEEF, 12'h0, 1'b0, cyc);
        chk("t4_cyc", cyc, 1);
        chk("t4_out", sif.ShiftOut, 16'hBEEF);
        sif.ShiftIn = 16'h1111; sif.Start = 1'b1;
        tick();
        sif.Start = 1'b0;
        chk("t4_ready", sif.Ready, 1);
        tick();
        chk("t4_nodone", sif.Done, 0);
        chk("t4_hold", sif.ShiftOut, 16'hBEEF);

        sif.Mode = 2'b00; sif.Dir = 1'b0; sif.Amt = 5'd8; sif.ShiftIn = 16'h00FF; sif.Start = 1'b1;
        tick();
        sif.Start = 1'b0;
        tick();
        tick();
        sif.Start = 1'b1; sif.ShiftIn = 16'hAAAA;
        tick();
        sif.Start = 1'b0; sif.Flush = 1'b1;
        tick();
        sif.Flush = 1'b0;
        chk("t5_ready", sif.Ready, 1);
        for (int i = 0; i < 12; i++) tick();
        chk("t5_hold", sif.ShiftOut, 16'hBEEF);

        sif.Amt = 5'd8; sif.ShiftIn = 16'h00FF; sif.Imm = 12'h123; sif.Start = 1'b1;
        tick();
        sif.Start = 1'b0;
        tick(); tick(); tick();
        CtrlRstN = 1'b0;
        #1;
        chk("t5r_ready", sif.Ready, 1);
        chk("t5r_done", sif.Done, 0);
        chk("t5r_out", sif.ShiftOut, 0);
        chk("t5r_ext", sif.ExtOut, 0);
        tick();
        CtrlRstN = 1'b1;
        tick();

`ifdef JALA_SHIFT_FLAGS_EN
        req(2'b00, 1'b0, 5'd1, 16'h8001, 12'h0, 1'b0, cyc);
        chk("t6a_out", sif.ShiftOut, 16'h0002);
        chk("t6a_carry", sif.ShiftCarry, 1);
        chk("t6a_zero", sif.ShiftZero, 0);
        tick();
        req(2'b00, 1'b1, 5'd1, 16'h0001, 12'h0, 1'b0, cyc);
        chk("t6b_out", sif.ShiftOut, 16'h0000);
        chk("t6b_zero", sif.ShiftZero, 1);
        chk("t6b_carry", sif.ShiftCarry, 1);
        tick();
`endif

        for (int i = 0; i < 4000; i++) begin
            sif.Start     = ($urandom % 3) == 0;
            sif.Flush     = ($urandom % 12) == 0;
            sif.Mode      = 2'($urandom);
            sif.Dir       = 1'($urandom);
            sif.Amt       = (($urandom % 3) == 0) ? 5'(picks[$urandom % 5]) : 5'($urandom);
            sif.ShiftIn   = (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom);
            sif.Imm       = 12'($urandom);
            sif.ImmSigned = 1'($urandom);
            tick();
        end
        sif.Start = 1'b0; sif.Flush = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_ext_unit.md
Name: shift_ext_unit

Overview:
Parametrised, multi-cycle successor to the stage-4 shifter/immediate-extender path of the 16-bit datapath.
- Accepts a shift request under a Start/Ready handshake and shifts iteratively, STEP bits per cycle.
- Supports logical, arithmetic and rotate modes in both directions.
- Signals completion with a one-cycle Done pulse.
- Registers a zero- or sign-extended immediate alongside each accepted request.
- Sits between IR/operand registers and the result mux; driven by the Control FSM.

Parameters:
- WIDTH, 16: datapath width in bits; must be ≥ IMM_W.
- STEP, 1: maximum bits shifted per cycle; power of two, 1..WIDTH.
- AMT_W, 5: shift-amount width; must be ≥ clog2(WIDTH).
- IMM_W, 12: immediate field width.

Ports:
- CLK, input, 1: clock, rising edge.
- CtrlRstN, input, 1: asynchronous active-low reset.
- Start, input, 1: request valid; accepted only when Ready=1.
- Ready, output, 1: unit idle and able to accept.
- Done, output, 1: one-cycle pulse; ShiftOut valid.
- Flush, input, 1: synchronous abort of an in-flight shift.
- Mode, input, 2: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- Dir, input, 1: 0 left, 1 right.
- Amt, input, AMT_W: shift amount, unsigned.
- ShiftIn, input, WIDTH: operand.
- ShiftOut, output, WIDTH: registered result; holds until the next Done.
- Imm, input, IMM_W: immediate field.
- ImmSigned, input, 1: 1 = sign-extend, 0 = zero-extend.
- ExtOut, output, WIDTH: registered extended immediate.

Behaviour:
- Reset (async, CtrlRstN=0): state IDLE, Ready=1, Done=0, ShiftOut=0, ExtOut=0, internal working register and counter cleared. Takes effect immediately, including mid-shift; no Done is produced for the aborted request.
- FSM states:
  - IDLE: Ready=1. On Start=1 (accept edge): latch ShiftIn into the working register and latch Mode/Dir; compute A_eff; load ExtOut.
    - Next state SHIFT if A_eff > 0, else DONE.
  - SHIFT: Ready=0. Each edge shifts the working register by min(STEP, remaining) and decrements remaining by the same amount.
    - When remaining reaches 0, go to DONE; ShiftOut is loaded from the working register on that same edge.
    - If A_eff = 0, ShiftOut is loaded on the accept edge.
  - DONE: Done=1, Ready=0 for exactly one cycle; then IDLE. Start during DONE is ignored.
- A_eff:
  - Logical/arithmetic: min(Amt, WIDTH).
  - Rotate: Amt mod WIDTH.
- Shift semantics:
  - Left logical and left arithmetic are identical; zeros fill the LSBs.
  - Right logical fills zeros into the MSBs.
  - Right arithmetic replicates the MSB latched at accept.
  - Rotate moves bits circularly.
  - Amt ≥ WIDTH gives all-zero for logical and all-sign for arithmetic right.
- Latency: Done is high in the cycle following edge 1 + ceil(A_eff/STEP) counted from the accept edge. With A_eff = 0, Done is high the cycle after the accept edge.
- ExtOut: Imm zero- or sign-extended (sign bit Imm[IMM_W-1]) to WIDTH, loaded on the accept edge only.
- Start while Ready=0 is ignored; no queueing.
- Flush:
  - In SHIFT: next state IDLE; no Done; ShiftOut and ExtOut keep their prior values.
  - In IDLE or DONE: no effect.
  - Flush and Start in the same IDLE cycle: Flush has priority and Start is dropped.

Optional Feature:
JALA_SHIFT_FLAGS_EN
- Defined: adds outputs ShiftZero (1 bit, high when ShiftOut==0) and ShiftCarry (1 bit, last bit shifted out).
  - Both are registered alongside ShiftOut and reset to 0.
  - ShiftCarry=0 when A_eff=0.
  - For rotate, ShiftCarry is the last bit that wrapped.
- Undefined: the ports do not exist and no flag logic is present.

Decomposition:
- Package shift_ext_pkg holds:
  - the mode encoding constants (MODE_LOG, MODE_ARI, MODE_ROT);
  - the state encoding (ST_IDLE, ST_SHIFT, ST_DONE);
  - the direction constants.
- One sub-module, shift_step: a combinational single-iteration shifter (working value, count ≤ STEP, mode, dir, latched sign) → shifted value and carry bit.
- The FSM, counter and extender live in shift_ext_unit.

Test Plan:
1. STEP=1; ShiftIn=0x00F1, Amt=4, Mode=00, Dir=0, Imm=0x800, ImmSigned=1 → ExtOut=0xF800 after the accept edge; Done in cycle 5, ShiftOut=0x0F10. Repeat with ImmSigned=0 → ExtOut=0x0800.
2. ShiftIn=0x8000, Mode=01, Dir=1: Amt=15 → 0xFFFF, Done in cycle 16; Amt=20 → 0xFFFF, Done in cycle 17.
3. Mode=10, Dir=1, ShiftIn=0x1234, Amt=20 (A_eff=4) → 0x4123. With STEP=4, Done in cycle 2.
4. Amt=0, ShiftIn=0xBEEF → ShiftOut=0xBEEF, Done in cycle 1. A second Start pulsed during DONE is ignored; Ready returns the next cycle.
5. Amt=8 shift in flight:
   - Start re-pulsed at cycle 3 → ignored.
   - Flush at cycle 4 → IDLE next cycle, no Done, ShiftOut unchanged.
   - Separately, CtrlRstN low at cycle 4 → all outputs reset immediately.
6. JALA_SHIFT_FLAGS_EN defined: 0x8001 left logical, Amt=1 → ShiftOut=0x0002, ShiftCarry=1, ShiftZero=0. Then 0x0001 right logical, Amt=1 → ShiftOut=0x0000, ShiftZero=1, ShiftCarry=1.
